// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - unsigned NxN shift-add multiplier built on a carry-lookahead adder

module CarryLookaheadAdder #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout
);

    logic [N-1:0] g;
    logic [N-1:0] pr;
    logic [N:0]   c;
    logic         pchain;

    assign g  = A & B;
    assign pr = A ^ B;

    // Each carry is the flattened sum-of-products of generate/propagate terms,
    // so no carry depends on a lower computed carry.
    always_comb begin
        c      = '0;
        pchain = 1'b0;
        c[0]   = Cin;
        for (int i = 0; i < N; i++) begin
            c[i+1] = g[i];
            pchain = pr[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pchain & g[j]);
                pchain = pchain & pr[j];
            end
            c[i+1] = c[i+1] | (pchain & Cin);
        end
    end

    assign S    = pr ^ c[N-1:0];
    assign Cout = c[N];

endmodule

module seq_multiplier #(
    parameter int N = 4
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           Start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           Busy,
    output logic           Done,
    output logic [2*N-1:0] P
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [N-1:0]  m;
    logic [N-1:0]  acc;
    logic [N-1:0]  q;
    logic [CW-1:0] cnt;
    logic [N-1:0]  addend;
    logic [N-1:0]  sum;
    logic          cout;
    logic          last;

    assign addend = q[0] ? m : '0;
    assign last   = (cnt == CW'(1));

    CarryLookaheadAdder #(.N(N)) u_cla (
        .A    (acc),
        .B    (addend),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (cout)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (Start) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Busy/Done are registered copies of the next state so they align with it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            m    <= '0;
            acc  <= '0;
            q    <= '0;
            cnt  <= '0;
            P    <= '0;
            Busy <= 1'b0;
            Done <= 1'b0;
        end else begin
            Busy <= (state_n != IDLE);
            Done <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (Start) begin
                        m   <= A;
                        q   <= B;
                        acc <= '0;
                        cnt <= CW'(N);
                    end
                end
                RUN: begin
                    {acc, q} <= {cout, sum, q[N-1:1]};
                    cnt      <= cnt - 1'b1;
                    if (last) begin
                        P <= {cout, sum, q[N-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier

module tb_seq_multiplier;

    localparam int N = 4;

    logic           Clk = 1'b0;
    logic           Rst;
    logic           Start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           Busy;
    logic           Done;
    logic [2*N-1:0] P;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    seq_multiplier #(.N(N)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .P     (P)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Observation k is taken on the falling edge after the k-th rising edge,
    // where edge 0 accepts Start; product expected is plain a*b at index N.
    task automatic run_op(input int a, input int b, input bit repulse, input bit timing);
        int          done_idx = -1;
        int          busy_cnt = 0;
        int          done_cnt = 0;
        logic [31:0] p_at = '0;
        @(negedge Clk);
        Start = 1'b1;
        A = N'(a);
        B = N'(b);
        for (int k = 0; k <= N + 3; k++) begin
            @(negedge Clk);
            if (Busy) busy_cnt++;
            if (Done) begin
                done_cnt++;
                done_idx = k;
                p_at = 32'(P);
            end
            if (repulse && k >= 1 && k <= 3) begin
                Start = 1'b1;
                A = N'(2);
                B = N'(2);
            end else begin
                Start = 1'b0;
                A = N'($urandom);
                B = N'($urandom);
            end
        end
        check($sformatf("done_count %0dx%0d", a, b), 32'(done_cnt), 32'd1);
        check($sformatf("product %0dx%0d", a, b), p_at, 32'(a * b));
        if (timing) begin
            check($sformatf("latency %0dx%0d", a, b), 32'(done_idx), 32'(N));
            check($sformatf("busy_cycles %0dx%0d", a, b), 32'(busy_cnt), 32'(N + 1));
        end
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int prev;
        int a;
        int b;

        Rst = 1'b1;
        Start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge Clk);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_p", 32'(P), 32'd0);
        Rst = 1'b0;

        run_op(0, 0, 1'b0, 1'b1);

        for (int v = 0; v < 16; v++) begin
            run_op(v, v, 1'b0, 1'b1);
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            run_op(a, b, 1'b0, 1'b0);
        end
        run_op(7, 9, 1'b0, 1'b1);
        run_op(15, 1, 1'b0, 1'b1);

        run_op(13, 11, 1'b1, 1'b1);

        // Reset sampled on the second RUN edge of 12x12.
        @(negedge Clk);
        Start = 1'b1;
        A = N'(12);
        B = N'(12);
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check("midrun_rst_busy", 32'(Busy), 32'd0);
        check("midrun_rst_p", 32'(P), 32'd0);
        check("midrun_rst_done", 32'(Done), 32'd0);
        done_cnt = 0;
        busy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (Done) done_cnt++;
            if (Busy) busy_cnt++;
        end
        check("midrun_rst_no_done", 32'(done_cnt), 32'd0);
        check("midrun_rst_no_busy", 32'(busy_cnt), 32'd0);
        run_op(5, 6, 1'b0, 1'b1);

        // Start held high: expect Done at indices N, N+(N+2), N+2(N+2).
        @(negedge Clk);
        Start = 1'b1;
        A = N'(3);
        B = N'(5);
        prev = -1;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (Done) begin
                done_cnt++;
                check("held_product", 32'(P), 32'd15);
                if (prev < 0) check("held_first_latency", 32'(k), 32'(N));
                else check("held_period", 32'(k - prev), 32'(N + 2));
                prev = k;
            end
        end
        Start = 1'b0;
        check("held_done_count", 32'(done_cnt), 32'd3);
        for (int k = 0; k < N + 3 && Busy; k++) @(negedge Clk);
        check("held_returns_idle", 32'(Busy), 32'd0);

        @(negedge Clk);
        Rst = 1'b1;
        Start = 1'b1;
        A = N'(9);
        B = N'(9);
        @(negedge Clk);
        Rst = 1'b0;
        Start = 1'b0;
        check("rst_start_busy", 32'(Busy), 32'd0);
        done_cnt = 0;
        busy_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (Done) done_cnt++;
            if (Busy) busy_cnt++;
        end
        check("rst_start_no_done", 32'(done_cnt), 32'd0);
        check("rst_start_no_busy", 32'(busy_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
